lcd_timing_gen: RTL



---
 rtl/lcd_timing_pkg.sv | 34 +++
 rtl/lcd_timing_gen_pixel_clk_div.sv | 33 +++
 rtl/lcd_timing_gen.sv | 94 +++++++++
 3 files changed

// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - shared timing constants and helpers for the 480x272 LCD raster
package lcd_timing_pkg;

  localparam int CLK_DIV_DEF  = 3;
  localparam int H_ACTIVE_DEF = 480;
  localparam int H_FRONT_DEF  = 8;
  localparam int H_SYNC_DEF   = 4;
  localparam int H_BACK_DEF   = 43;
  localparam int V_ACTIVE_DEF = 272;
  localparam int V_FRONT_DEF  = 8;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BACK_DEF   = 12;

  localparam int HCNT_W  = 10;
  localparam int VCNT_W  = 9;
  localparam int PHASE_W = 4;

  function automatic int span_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int sync_first(input int active, input int front);
    return active + front;
  endfunction

  function automatic int sync_last(input int active, input int front, input int sync);
    return active + front + sync - 1;
  endfunction

  localparam int H_TOTAL = span_total(H_ACTIVE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL = span_total(V_ACTIVE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/lcd_timing_gen_pixel_clk_div.sv
// rtl/lcd_timing_gen_pixel_clk_div.sv - phase counter producing pixel strobe and panel clock
module pixel_clk_div
  import lcd_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clock,
  input  logic reset,
  output logic tick,
  output logic pixel_en,
  output logic lcd_clk
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_DIV - 1);

  logic [PHASE_W-1:0] phase;

  // >= so a corrupted phase still wraps on the next clock
  assign tick = (phase >= PHASE_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase    <= '0;
      pixel_en <= 1'b0;
      lcd_clk  <= 1'b0;
    end else begin
      phase    <= tick ? '0 : phase + 1'b1;
      pixel_en <= tick;
      lcd_clk  <= (phase == '0);
    end
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - raster timing generator: sync, display enable and pixel coordinates
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF
) (
  input  logic       clock,
  input  logic       reset,
  output logic       pixel_en,
  output logic       lcd_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic       frame_start
);

  localparam int LINE_TOTAL  = span_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int FRAME_TOTAL = span_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [HCNT_W-1:0] H_LAST    = HCNT_W'(LINE_TOTAL - 1);
  localparam logic [HCNT_W-1:0] H_ACT     = HCNT_W'(H_ACTIVE);
  localparam logic [HCNT_W-1:0] H_SYNC_LO = HCNT_W'(sync_first(H_ACTIVE, H_FRONT));
  localparam logic [HCNT_W-1:0] H_SYNC_HI = HCNT_W'(sync_last(H_ACTIVE, H_FRONT, H_SYNC));
  localparam logic [VCNT_W-1:0] V_LAST    = VCNT_W'(FRAME_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_ACT     = VCNT_W'(V_ACTIVE);
  localparam logic [VCNT_W-1:0] V_SYNC_LO = VCNT_W'(sync_first(V_ACTIVE, V_FRONT));
  localparam logic [VCNT_W-1:0] V_SYNC_HI = VCNT_W'(sync_last(V_ACTIVE, V_FRONT, V_SYNC));

  logic              tick;
  logic              h_wrap;
  logic              on_next;
  logic [HCNT_W-1:0] h_cnt, h_next;
  logic [VCNT_W-1:0] v_cnt, v_next;

  pixel_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_clk_div (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .pixel_en (pixel_en),
    .lcd_clk  (lcd_clk)
  );

  // Out-of-range counts fall back to 0 rather than running past the totals
  always_comb begin
    h_wrap = (h_cnt >= H_LAST);
    h_next = h_wrap ? '0 : h_cnt + 1'b1;
    v_next = v_cnt;
    if (v_cnt > V_LAST) begin
      v_next = '0;
    end else if (h_wrap) begin
      v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
    on_next = (h_next < H_ACT) && (v_next < V_ACT);
  end

  // Outputs decode the next counter values so they land with the counter update
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      display_on  <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        h_cnt       <= h_next;
        v_cnt       <= v_next;
        hsync       <= !((h_next >= H_SYNC_LO) && (h_next <= H_SYNC_HI));
        vsync       <= !((v_next >= V_SYNC_LO) && (v_next <= V_SYNC_HI));
        display_on  <= on_next;
        x           <= on_next ? h_next[8:0] : '0;
        y           <= on_next ? v_next[8:0] : '0;
        frame_start <= (h_next == '0) && (v_next == '0);
      end
    end
  end

endmodule
